// File: rtl/icache_pkg.sv
// Shared state encoding and address-split geometry for the instruction cache controller.
// Geometry macros ICACHE_SIZE, ICACHE_INDEX, ITAGMSB and ITAGLSB default here when not predefined.
`ifndef ICACHE_SIZE
`define ICACHE_SIZE 64
`endif
`ifndef ICACHE_INDEX
`define ICACHE_INDEX 6
`endif
`ifndef ITAGLSB
`define ITAGLSB (`ICACHE_INDEX + 4)
`endif
`ifndef ITAGMSB
`define ITAGMSB 31
`endif

package icache_pkg;

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_FILL,
        ST_UPDATE
    } state_t;

    localparam int LINE_WORDS_DEF = 4;
    localparam int INDEX_W        = `ICACHE_INDEX;
    localparam int TAG_LSB        = `ITAGLSB;
    localparam int TAG_MSB        = `ITAGMSB;
    localparam int TAG_W          = TAG_MSB - TAG_LSB + 1;
    // Byte offset inside a line: everything below the index field.
    localparam int OFFSET_W       = TAG_LSB - INDEX_W;
    localparam int ENTRIES        = `ICACHE_SIZE;

endpackage

// File: rtl/icache_tag_cmp.sv
// Combinational tag match: a stored entry hits when it is valid and its tag equals the fetch tag.
module icache_tag_cmp
    import icache_pkg::*;
#(
    parameter int W = TAG_W
) (
    input  logic         valid,
    input  logic [W-1:0] stored_tag,
    input  logic [W-1:0] pc_tag,
    output logic         hit
);

    assign hit = valid & (stored_tag == pc_tag);

endmodule

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped instruction cache controller: lookup, line fill, tag update and invalidate-all.
// Define ICACHE_PERF_CNT_EN to build the saturating hit/miss counters; otherwise they read 0.
module inst_cache_ctrl
    import icache_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int ADDR_W     = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pc_valid,
    input  logic [ADDR_W-1:0]             pc,
    input  logic                          flush,
    output logic                          hit,
    output logic                          stall,
    output logic                          tag_we,
    output logic [`ICACHE_INDEX-1:0]      tag_index,
    output logic                          tag_valid_in,
    output logic [`ITAGMSB:`ITAGLSB]      tag_in,
    input  logic                          tag_valid_out,
    input  logic [`ITAGMSB:`ITAGLSB]      tag_out,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_gnt,
    input  logic                          mem_rvalid,
    output logic                          data_we,
    output logic [`ICACHE_INDEX-1:0]      data_index,
    output logic [$clog2(LINE_WORDS)-1:0] data_word,
    output logic [31:0]                   hit_cnt,
    output logic [31:0]                   miss_cnt
);

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(LINE_WORDS - 1);
    localparam logic [INDEX_W-1:0] LAST_ENTRY = INDEX_W'(ENTRIES - 1);

    state_t               state;
    logic [INDEX_W-1:0]   flush_cnt;
    logic [WORD_W-1:0]    word_cnt;
    logic                 pending;
    logic [TAG_W-1:0]     cap_tag;
    logic [INDEX_W-1:0]   cap_index;

    logic [TAG_W-1:0]     pc_tag;
    logic [INDEX_W-1:0]   pc_index;
    logic                 tag_match;
    logic                 lookup;
    logic                 miss;
    logic [ADDR_W-1:0]    fill_addr;
    logic                 unused_offset;

    assign pc_tag        = pc[TAG_MSB:TAG_LSB];
    assign pc_index      = pc[TAG_LSB-1:OFFSET_W];
    assign unused_offset = ^pc[OFFSET_W-1:0];

    icache_tag_cmp #(.W(TAG_W)) u_tag_cmp (
        .valid      (tag_valid_out),
        .stored_tag (tag_out),
        .pc_tag     (pc_tag),
        .hit        (tag_match)
    );

    // A flush in LOOKUP masks both the hit and the miss of the same cycle.
    assign lookup = (state == ST_LOOKUP);
    assign hit    = lookup & pc_valid & ~flush & tag_match;
    assign miss   = lookup & pc_valid & ~flush & ~tag_match;
    assign stall  = lookup ? (pc_valid & ~hit) : 1'b1;

    always_comb begin
        fill_addr                    = '0;
        fill_addr[TAG_MSB:TAG_LSB]   = cap_tag;
        fill_addr[TAG_LSB-1:OFFSET_W] = cap_index;
    end

    always_comb begin
        tag_we       = 1'b0;
        tag_valid_in = 1'b0;
        tag_in       = cap_tag;
        tag_index    = pc_index;
        mem_req      = 1'b0;
        mem_addr     = fill_addr;
        data_we      = 1'b0;
        data_index   = cap_index;
        data_word    = word_cnt;
        case (state)
            ST_FLUSH: begin
                tag_we    = 1'b1;
                tag_index = flush_cnt;
            end
            ST_MISS_REQ: mem_req = 1'b1;
            ST_FILL:     data_we = mem_rvalid;
            ST_UPDATE: begin
                tag_we       = 1'b1;
                tag_valid_in = 1'b1;
                tag_index    = cap_index;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
            word_cnt  <= '0;
            pending   <= 1'b0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    flush_cnt <= flush_cnt + 1'b1;
                    if (flush_cnt == LAST_ENTRY) begin
                        flush_cnt <= '0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (flush)     state <= ST_FLUSH;
                    else if (miss) state <= ST_MISS_REQ;
                end
                ST_MISS_REQ: begin
                    if (flush)   pending <= 1'b1;
                    if (mem_gnt) state   <= ST_FILL;
                end
                ST_FILL: begin
                    if (flush) pending <= 1'b1;
                    if (mem_rvalid) begin
                        word_cnt <= word_cnt + 1'b1;
                        if (word_cnt == LAST_WORD) state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    pending <= 1'b0;
                    state   <= (pending | flush) ? ST_FLUSH : ST_LOOKUP;
                end
                default: state <= ST_FLUSH;
            endcase
        end
    end

    // Miss address capture is pure data and needs no reset.
    always_ff @(posedge clock) begin
        if (miss) begin
            cap_tag   <= pc_tag;
            cap_index <= pc_index;
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)  hit_cnt  <= sat_inc(hit_cnt);
            if (miss) miss_cnt <= sat_inc(miss_cnt);
        end
    end
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_cache_ctrl.sv
// Self-checking bench for inst_cache_ctrl with a behavioural tag RAM and scripted memory responses.
// Expected fill words and tag writes are queued as stimulus is driven and popped by a monitor.
`ifndef ICACHE_SIZE
`define ICACHE_SIZE 64
`endif
`ifndef ICACHE_INDEX
`define ICACHE_INDEX 6
`endif
`ifndef ITAGLSB
`define ITAGLSB (`ICACHE_INDEX + 4)
`endif
`ifndef ITAGMSB
`define ITAGMSB 31
`endif

module tb_inst_cache_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pc_valid = 1'b0;
    logic [31:0] pc = '0;
    logic        flush = 1'b0;
    logic        hit, stall, tag_we, tag_valid_in;
    logic [5:0]  tag_index;
    logic [21:0] tag_in;
    logic        tag_valid_out;
    logic [21:0] tag_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic        data_we;
    logic [5:0]  data_index;
    logic [1:0]  data_word;
    logic [31:0] hit_cnt, miss_cnt;

    typedef struct packed { logic [5:0] idx; logic [1:0] word; } dw_t;
    typedef struct packed { logic [5:0] idx; logic [21:0] tag; } tw_t;
    dw_t exp_dw[$];
    tw_t exp_tw[$];
    dw_t mon_dw;
    tw_t mon_tw;

    int n_cmp  = 0;
    int n_fail = 0;

    logic        tv [64];
    logic [21:0] tt [64];

    always #5 clock = ~clock;

    inst_cache_ctrl #(.LINE_WORDS(4), .ADDR_W(32)) dut (
        .clock(clock), .reset(reset), .pc_valid(pc_valid), .pc(pc), .flush(flush),
        .hit(hit), .stall(stall), .tag_we(tag_we), .tag_index(tag_index),
        .tag_valid_in(tag_valid_in), .tag_in(tag_in), .tag_valid_out(tag_valid_out),
        .tag_out(tag_out), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .data_we(data_we), .data_index(data_index),
        .data_word(data_word), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always @(posedge clock) begin
        if (tag_we) begin
            tv[tag_index] <= tag_valid_in;
            tt[tag_index] <= tag_in;
        end
    end
    assign tag_valid_out = tv[tag_index];
    assign tag_out       = tt[tag_index];

    always @(negedge clock) begin
        if (!reset && data_we) begin
            n_cmp++;
            if (exp_dw.size() == 0) begin
                n_fail++;
                $display("FAIL data_we_unexpected got idx=%0d word=%0d want no write", data_index, data_word);
            end else begin
                mon_dw = exp_dw.pop_front();
                if ({data_index, data_word} !== {mon_dw.idx, mon_dw.word}) begin
                    n_fail++;
                    $display("FAIL data_write got idx=%0d word=%0d want idx=%0d word=%0d",
                             data_index, data_word, mon_dw.idx, mon_dw.word);
                end
            end
        end
        if (!reset && tag_we && tag_valid_in) begin
            n_cmp++;
            if (exp_tw.size() == 0) begin
                n_fail++;
                $display("FAIL tag_write_unexpected got idx=%0d tag=%0h want no valid write", tag_index, tag_in);
            end else begin
                mon_tw = exp_tw.pop_front();
                if ({tag_index, tag_in} !== {mon_tw.idx, mon_tw.tag}) begin
                    n_fail++;
                    $display("FAIL tag_write got idx=%0d tag=%0h want idx=%0d tag=%0h",
                             tag_index, tag_in, mon_tw.idx, mon_tw.tag);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clock);
        n_cmp++;
        if ({hit, stall, mem_req, data_we} !== 4'b0100 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL %s got hit=%b stall=%b req=%b dwe=%b hc=%0d mc=%0d want 0 1 0 0 0 0",
                     name, hit, stall, mem_req, data_we, hit_cnt, miss_cnt);
        end
    endtask

    // Entered just after a clock edge with the DUT in FLUSH at entry 0; leaves at a falling edge in LOOKUP.
    task automatic wait_flush();
        int cnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (!tag_we) break;
            n_cmp++;
            if (tag_index !== 6'(cnt) || tag_valid_in !== 1'b0 || stall !== 1'b1 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_entry got idx=%0d vin=%b stall=%b req=%b want idx=%0d vin=0 stall=1 req=0",
                         tag_index, tag_valid_in, stall, mem_req, cnt);
            end
            cnt++;
        end
        n_cmp++;
        if (cnt != 64 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_length got entries=%0d stall=%b want entries=64 stall=0", cnt, stall);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; pc_valid = 1'b0; flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        check_reset_outputs("reset_outputs");
        tick();
        reset = 1'b0;
        wait_flush();
        tick();
    endtask

    task automatic fetch_miss(input logic [31:0] addr, input int gnt_delay, input int flush_word);
        dw_t e;
        tw_t t;
        pc_valid = 1'b1;
        pc = addr;
        for (int w = 0; w < 4; w++) begin
            e.idx = addr[9:4]; e.word = 2'(w);
            exp_dw.push_back(e);
        end
        t.idx = addr[9:4]; t.tag = addr[31:10];
        exp_tw.push_back(t);
        @(negedge clock);
        n_cmp++;
        if (hit !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_detect pc=%0h got hit=%b stall=%b want hit=0 stall=1", addr, hit, stall);
        end
        tick();
        for (int c = 0; c <= gnt_delay; c++) begin
            mem_gnt = (c == gnt_delay);
            @(negedge clock);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== {addr[31:4], 4'h0} || stall !== 1'b1) begin
                n_fail++;
                $display("FAIL miss_request got req=%b addr=%0h stall=%b want req=1 addr=%0h stall=1",
                         mem_req, mem_addr, stall, {addr[31:4], 4'h0});
            end
            tick();
        end
        mem_gnt = 1'b0;
        for (int w = 0; w < 4; w++) begin
            mem_rvalid = 1'b1;
            flush = (w == flush_word);
            @(negedge clock);
            tick();
            mem_rvalid = 1'b0;
            flush = 1'b0;
            if (w == 1) begin
                @(negedge clock);
                n_cmp++;
                if (data_we !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b1 || tag_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_gap got dwe=%b req=%b stall=%b twe=%b want 0 0 1 0",
                             data_we, mem_req, stall, tag_we);
                end
                tick();
            end
        end
        @(negedge clock);
        n_cmp++;
        if (tag_we !== 1'b1 || tag_valid_in !== 1'b1 || tag_index !== addr[9:4] || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL update got twe=%b vin=%b idx=%0d stall=%b want 1 1 %0d 1",
                     tag_we, tag_valid_in, tag_index, stall, addr[9:4]);
        end
        tick();
        if (flush_word >= 0) begin
            pc_valid = 1'b0;
            wait_flush();
            tick();
        end else begin
            @(negedge clock);
            n_cmp++;
            if (hit !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL refetch_hit got hit=%b stall=%b req=%b want 1 0 0", hit, stall, mem_req);
            end
            tick();
            pc_valid = 1'b0;
        end
        n_cmp++;
        if (exp_dw.size() != 0 || exp_tw.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got dw=%0d tw=%0d want 0 0", exp_dw.size(), exp_tw.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_cold_fetch();
        fetch_miss(32'h100, 2, -1);
        pc_valid = 1'b1;
        pc = 32'h104;
        @(negedge clock);
        n_cmp++;
        if (hit !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL same_line_hit got hit=%b stall=%b req=%b want 1 0 0", hit, stall, mem_req);
        end
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic test_ignore();
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            n_cmp++;
            if (data_we !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || tag_we !== 1'b0) begin
                n_fail++;
                $display("FAIL stray_mem_inputs got dwe=%b req=%b stall=%b twe=%b want 0 0 0 0",
                         data_we, mem_req, stall, tag_we);
            end
            tick();
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic test_conflict();
        fetch_miss(32'h500, 1, -1);
        fetch_miss(32'h100, 0, -1);
    endtask

    task automatic test_flush_lookup();
        pc_valid = 1'b1;
        pc = 32'h104;
        flush = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (hit !== 1'b0 || stall !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_priority got hit=%b stall=%b want 0 1", hit, stall);
        end
        tick();
        flush = 1'b0;
        pc_valid = 1'b0;
        wait_flush();
        tick();
    endtask

    task automatic test_flush_during_fill();
        fetch_miss(32'h300, 0, 2);
        fetch_miss(32'h100, 0, -1);
    endtask

    task automatic test_reset_mid_fill();
        dw_t e;
        pc_valid = 1'b1;
        pc = 32'h700;
        for (int w = 0; w < 2; w++) begin
            e.idx = 6'h30; e.word = 2'(w);
            exp_dw.push_back(e);
        end
        @(negedge clock);
        tick();
        mem_gnt = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h700) begin
            n_fail++;
            $display("FAIL abort_request got req=%b addr=%0h want 1 700", mem_req, mem_addr);
        end
        tick();
        mem_gnt = 1'b0;
        mem_rvalid = 1'b1;
        repeat (2) begin
            @(negedge clock);
            tick();
        end
        mem_rvalid = 1'b0;
        pc_valid = 1'b0;
        reset = 1'b1;
        check_reset_outputs("reset_mid_fill");
        n_cmp++;
        if (exp_dw.size() != 0 || exp_tw.size() != 0) begin
            n_fail++;
            $display("FAIL abort_words got dw=%0d tw=%0d want 0 0", exp_dw.size(), exp_tw.size());
        end
        tick();
        reset = 1'b0;
        wait_flush();
        n_cmp++;
        if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL counters_after_reset got hc=%0d mc=%0d want 0 0", hit_cnt, miss_cnt);
        end
        tick();
        fetch_miss(32'h700, 0, -1);
    endtask

    task automatic test_counters();
        logic [31:0] want_hits;
        logic [31:0] want_misses;
`ifdef ICACHE_PERF_CNT_EN
        want_hits = 32'd4;
        want_misses = 32'd1;
`else
        want_hits = 32'd0;
        want_misses = 32'd0;
`endif
        do_reset();
        fetch_miss(32'h200, 0, -1);
        pc_valid = 1'b1;
        pc = 32'h204;
        repeat (3) begin
            @(negedge clock);
            n_cmp++;
            if (hit !== 1'b1) begin
                n_fail++;
                $display("FAIL repeat_hit got hit=%b want 1", hit);
            end
            tick();
        end
        pc_valid = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (hit_cnt !== want_hits || miss_cnt !== want_misses) begin
            n_fail++;
            $display("FAIL perf_counters got hc=%0d mc=%0d want hc=%0d mc=%0d",
                     hit_cnt, miss_cnt, want_hits, want_misses);
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_fetch();
        test_ignore();
        test_conflict();
        test_flush_lookup();
        test_flush_during_fill();
        test_reset_mid_fill();
        test_counters();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_cache_ctrl.md
INST_CACHE_CTRL -- requirements
Module: inst_cache_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, giving the 32-bit words per cache line (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, giving the fetch address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clock is named clock, reset is named reset.
REQ-004 SHALL have these ports, in order:
  clock           in   1                   system clock
  reset           in   1                   async active-high reset
  pc_valid        in   1                   fetch request
  pc              in   ADDR_W              fetch byte address
  flush           in   1                   invalidate-all request (1-cycle pulse)
  hit             out  1                   fetch hits this cycle
  stall           out  1                   fetch cannot complete
  tag_we          out  1                   tag RAM write enable
  tag_index       out  `ICACHE_INDEX       tag RAM index
  tag_valid_in    out  1                   valid bit to write
  tag_in          out  `ITAGMSB:`ITAGLSB   tag to write
  tag_valid_out   in   1                   tag RAM valid (combinational read)
  tag_out         in   `ITAGMSB:`ITAGLSB   tag RAM tag (combinational read)
  mem_req         out  1                   line-fill request
  mem_addr        out  ADDR_W              line-aligned fill address
  mem_gnt         in   1                   memory accepts request
  mem_rvalid      in   1                   one fill word returned
  data_we         out  1                   data RAM word write
  data_index      out  `ICACHE_INDEX       data RAM line index
  data_word       out  log2(LINE_WORDS)    word within line
  hit_cnt         out  32                  hit counter
  miss_cnt        out  32                  miss counter

Function
REQ-005 SHALL split pc as follows: tag = pc[`ITAGMSB:`ITAGLSB]; index = the `ICACHE_INDEX bits directly below `ITAGLSB; bits below the index are the offset.
REQ-006 SHALL implement the FSM states FLUSH, LOOKUP, MISS_REQ, FILL and UPDATE.
REQ-007 In LOOKUP, tag_index SHALL equal the pc index, and hit SHALL be pc_valid & tag_valid_out & (tag_out==pc tag) in the same cycle (zero latency), with stall=0.
REQ-008 In LOOKUP, a pc_valid miss SHALL capture the pc tag and index, assert stall, and move to MISS_REQ next cycle.
REQ-009 In MISS_REQ, mem_req=1 and mem_addr = the captured address with the offset zeroed; both SHALL hold until mem_gnt=1, then the FSM moves to FILL.
REQ-010 In FILL, each mem_rvalid SHALL produce a one-cycle data_we, with data_index = the captured index and data_word = the word counter (starting at 0); the counter increments afterwards.
REQ-011 In FILL, the mem_rvalid of word LINE_WORDS-1 SHALL move the FSM to UPDATE; the counter wraps to 0.
REQ-012 In UPDATE, the block SHALL assert tag_we=1, tag_valid_in=1, tag_in = the captured tag and tag_index = the captured index for one cycle, then return to LOOKUP; the re-lookup hits the following cycle.
REQ-013 In FLUSH, a counter 0..`ICACHE_SIZE-1 SHALL drive tag_index with tag_we=1 and tag_valid_in=0, one entry per cycle, with stall=1; after the last entry the FSM returns to LOOKUP.
REQ-014 flush in LOOKUP SHALL take priority over a same-cycle miss: the FSM enters FLUSH and hit=0.
REQ-015 flush in MISS_REQ/FILL/UPDATE SHALL set a pending flag; the fill completes, and UPDATE then goes to FLUSH instead of LOOKUP.
REQ-016 mem_rvalid outside FILL SHALL be ignored; mem_gnt outside MISS_REQ SHALL be ignored.
REQ-017 stall SHALL be 1 in every state except LOOKUP; in LOOKUP, stall = pc_valid & ~hit.
REQ-018 tag_we, data_we and mem_req SHALL be 0 in every state not named for them above.

Reset
REQ-019 reset SHALL asynchronously force state=FLUSH, flush counter=0, word counter=0 and pending flag=0.
REQ-020 During reset, outputs SHALL be: hit=0, stall=1, mem_req=0, data_we=0, hit_cnt=0, miss_cnt=0.
REQ-021 Reset asserted mid-fill SHALL abandon the fill; no tag write occurs, and a full flush follows release.

Configuration
REQ-022 With ICACHE_PERF_CNT_EN defined: hit_cnt increments on each hit cycle, and miss_cnt increments on each LOOKUP->MISS_REQ transition; both saturate at 2^32-1.
REQ-023 Without ICACHE_PERF_CNT_EN: hit_cnt and miss_cnt SHALL be constant 0, and no counter flops SHALL be synthesized.

Structure
REQ-024 The state enum, LINE_WORDS default and address-split helper widths SHALL live in shared package icache_pkg.
REQ-025 The tag comparison SHALL be sub-module icache_tag_cmp (combinational: valid, stored tag, pc tag -> hit); everything else stays in inst_cache_ctrl.

Verification
REQ-026 Release reset with `ICACHE_SIZE=64 -> exactly 64 tag_we cycles with tag_valid_in=0, indices 0..63, then LOOKUP with stall=0 when pc_valid=0.
REQ-027 Cold fetch of pc=0x100 with mem_gnt after 2 cycles and 4 rvalids -> mem_addr=0x100, data_word 0,1,2,3, one UPDATE writing tag(0x100), then hit=1 for 0x104 with no mem_req.
REQ-028 Fetch 0x100, then conflicting 0x100+(`ICACHE_SIZE*16) -> miss, refill, and the tag is overwritten; refetch of 0x100 misses again.
REQ-029 flush pulse during FILL word 2 -> the fill finishes, UPDATE occurs, then FLUSH; a later fetch of 0x100 misses.
REQ-030 Reset asserted in FILL after word 1 -> no tag_we with valid=1; post-reset flush completes; with ICACHE_PERF_CNT_EN, counters read 0.
